// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: drives every {A,B,C} vector into a combinational circuit under test,
// holds each one for SETTLE cycles, samples the response E and compares the resulting
// 8-entry table against a golden EXPECTED table.
module truth_table_sequencer #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'b1010_1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       e_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] captured_o,
  output logic       pass_o,
  output logic [2:0] fail_index_o
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  captured_q;
  logic        pass_q;
  logic [2:0]  fail_q;
  logic [7:0]  cap_sampled;

  // Lowest table entry that disagrees with the golden table; 0 when all match.
  function automatic logic [2:0] first_mismatch(input logic [7:0] cap);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cap[i] != EXPECTED[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Captured table with the current vector's response merged in, so the verdict at the
  // last SAMPLE already includes bit 7.
  always_comb begin
    cap_sampled        = captured_q;
    cap_sampled[idx_q] = e_i;
  end

  // Sweep FSM with all outputs held in registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start wins over abort here; abort is meaningless in IDLE
          if (start_i) begin
            state_q    <= StDrive;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            captured_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
          end
        end
        StDrive: begin
          if (abort_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (cnt_q == SettleLast) begin
            state_q <= StSample;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StSample: begin
          if (abort_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            captured_q <= cap_sampled;
            if (idx_q == 3'd7) begin
              // idx returns to 0 so the stimulus reads 000 in DONE
              state_q <= StDone;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (cap_sampled == EXPECTED);
              fail_q  <= first_mismatch(cap_sampled);
            end else begin
              state_q <= StDrive;
              idx_q   <= idx_q + 3'd1;
              cnt_q   <= '0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_o          = idx_q[2];
  assign b_o          = idx_q[1];
  assign c_o          = idx_q[0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign captured_o   = captured_q;
  assign pass_o       = pass_q;
  assign fail_index_o = fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a behavioural circuit-under-test model answers the
// DUT's stimulus; each task drives one scenario and checks hand-computed expectations.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  int   mode;
  int   checks = 0;
  int   errors = 0;

  logic       a, b, c, e, busy, done, pass;
  logic [7:0] cap;
  logic [2:0] fi;

  logic       a1, b1, c1, e1, busy1, done1, pass1;
  logic [7:0] cap1;
  logic [2:0] fi1;

  logic       a15, b15, c15, e15, busy15, done15, pass15;
  logic [7:0] cap15;
  logic [2:0] fi15;

  // Circuit-under-test models: 0 = (A|B)&C, 1 = stuck at 0, 2 = A&B, other = stuck at 1.
  always_comb begin
    case (mode)
      0:       e = (a | b) & c;
      1:       e = 1'b0;
      2:       e = a & b;
      default: e = 1'b1;
    endcase
  end
  assign e1  = (a1 | b1) & c1;
  assign e15 = (a15 | b15) & c15;

  truth_table_sequencer #(.SETTLE(2), .EXPECTED(8'b1010_1000)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .e_i(e),
    .a_o(a), .b_o(b), .c_o(c), .busy_o(busy), .done_o(done),
    .captured_o(cap), .pass_o(pass), .fail_index_o(fi)
  );

  truth_table_sequencer #(.SETTLE(1), .EXPECTED(8'b1010_1000)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .e_i(e1),
    .a_o(a1), .b_o(b1), .c_o(c1), .busy_o(busy1), .done_o(done1),
    .captured_o(cap1), .pass_o(pass1), .fail_index_o(fi1)
  );

  truth_table_sequencer #(.SETTLE(15), .EXPECTED(8'b1010_1000)) dut15 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .e_i(e15),
    .a_o(a15), .b_o(b15), .c_o(c15), .busy_o(busy15), .done_o(done15),
    .captured_o(cap15), .pass_o(pass15), .fail_index_o(fi15)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; mode = 0;
    tick; tick;
    checks++;
    if ({busy, done, a, b, c, cap, pass, fi} !== 16'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b abc=%b%b%b cap=%h pass=%b fi=%0d, want all zero",
               busy, done, a, b, c, cap, pass, fi);
    end
    rst = 1'b0; start = 1'b0;
    tick;
  endtask

  // Full sweep from IDLE; edge 0 is the start edge. Optionally pulses start mid-sweep.
  task automatic run_sweep(input int m, input logic [7:0] exp_cap, input logic exp_pass,
                           input logic [2:0] exp_fi, input bit poke_start, input string name);
    logic [2:0] exp_v;
    mode = m;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k != 0) tick;
      if (poke_start && k == 11) start = 1'b1;
      if (k == 12) start = 1'b0;
      exp_v = 3'(k / 3);
      checks++;
      if ({a, b, c} !== exp_v || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s vec k=%0d: abc=%b%b%b busy=%b done=%b, want abc=%b busy=1 done=0",
                 name, k, a, b, c, busy, done, exp_v);
      end
    end
    tick;  // edge 24
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {a, b, c} !== 3'b000 || cap !== exp_cap ||
        pass !== exp_pass || fi !== exp_fi) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b abc=%b%b%b cap=%b pass=%b fi=%0d, want done=1 busy=0 abc=000 cap=%b pass=%b fi=%0d",
               name, done, busy, a, b, c, cap, pass, fi, exp_cap, exp_pass, exp_fi);
    end
    tick;  // edge 25
    checks++;
    if (done !== 1'b0 || cap !== exp_cap || pass !== exp_pass || fi !== exp_fi) begin
      errors++;
      $display("FAIL %s hold: done=%b cap=%b pass=%b fi=%0d, want done=0 cap=%b pass=%b fi=%0d",
               name, done, cap, pass, fi, exp_cap, exp_pass, exp_fi);
    end
  endtask

  task automatic test_truth_tables;
    run_sweep(0, 8'b1010_1000, 1'b1, 3'd0, 1'b0, "good_model");
    run_sweep(1, 8'h00,        1'b0, 3'd3, 1'b0, "stuck0");
    run_sweep(2, 8'b1100_0000, 1'b0, 3'd3, 1'b0, "and_model");
  endtask

  task automatic test_start_ignored;
    run_sweep(0, 8'b1010_1000, 1'b1, 3'd0, 1'b1, "start_ignored");
  endtask

  task automatic test_abort;
    int seen;
    mode = 3;
    tick;
    start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    repeat (10) tick;  // edge 10
    abort = 1'b1;
    tick;  // edge 11
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cap !== 8'h07 || pass !== 1'b0 ||
        {a, b, c} !== 3'b000) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b cap=%h pass=%b abc=%b%b%b, want busy=0 done=0 cap=07 pass=0 abc=000",
               busy, done, cap, pass, a, b, c);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: active cycles=%0d, want 0", seen);
    end
    run_sweep(0, 8'b1010_1000, 1'b1, 3'd0, 1'b0, "after_abort");
    // start and abort together in IDLE: start wins
    tick;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_vs_abort: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_rst_mid;
    int seen;
    mode = 3;
    start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    repeat (6) tick;  // edge 6
    checks++;
    if (cap !== 8'h03 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: cap=%h busy=%b, want cap=03 busy=1", cap, busy);
    end
    rst = 1'b1;
    tick;  // edge 7
    rst = 1'b0;
    checks++;
    if ({busy, done, a, b, c, cap, pass, fi} !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b abc=%b%b%b cap=%h pass=%b fi=%0d, want all zero",
               busy, done, a, b, c, cap, pass, fi);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_done: done pulses=%0d, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int d_first, d_second;
    logic busy25, busy26;
    mode = 0; d_first = 0; d_second = 0; busy25 = 1'bx; busy26 = 1'bx;
    start = 1'b1;
    tick;  // edge 0
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (k == 25) busy25 = busy;
      if (k == 26) busy26 = busy;
      if (done === 1'b1) begin
        if (d_first == 0) d_first = k;
        else if (d_second == 0) d_second = k;
      end
    end
    start = 1'b0;
    repeat (30) tick;
    checks++;
    if (d_first != 24 || d_second != 50) begin
      errors++;
      $display("FAIL back_to_back: done edges %0d,%0d, want 24,50", d_first, d_second);
    end
    checks++;
    if (busy25 !== 1'b0 || busy26 !== 1'b1) begin
      errors++;
      $display("FAIL idle_gap: busy@25=%b busy@26=%b, want 0,1", busy25, busy26);
    end
  endtask

  task automatic test_settle;
    int d1, d15;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    d1 = 0; d15 = 0; mode = 0;
    start = 1'b1;
    tick;  // edge 0
    start = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      tick;
      if (done1 === 1'b1 && d1 == 0) d1 = k;
      if (done15 === 1'b1 && d15 == 0) d15 = k;
    end
    checks++;
    if (d1 != 16 || pass1 !== 1'b1 || cap1 !== 8'b1010_1000) begin
      errors++;
      $display("FAIL settle1: done edge=%0d pass=%b cap=%b, want 16 1 10101000", d1, pass1, cap1);
    end
    checks++;
    if (d15 != 128 || pass15 !== 1'b1 || cap15 !== 8'b1010_1000) begin
      errors++;
      $display("FAIL settle15: done edge=%0d pass=%b cap=%b, want 128 1 10101000",
               d15, pass15, cap15);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    test_reset;
    test_truth_tables;
    test_start_ignored;
    test_abort;
    test_rst_mid;
    test_back_to_back;
    test_settle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
